// File: rtl/switch_debounce_pkg.sv
// Shared types, defaults and helpers for the four-switch debounce front end.
// The optional freeze input is enabled by defining SWITCH_DEBOUNCE_HOLD_EN.
package switch_debounce_pkg;

    // Four-bit switch vector: [3]=A, [2]=B, [1]=C, [0]=D.
    typedef logic [3:0] sw_vec_t;

    // Per-bit debounce FSM states.
    typedef enum logic [0:0] {
        DB_STABLE   = 1'b0,
        DB_COUNTING = 1'b1
    } db_state_t;

    // 10 ms at 50 MHz.
    localparam int DB_CNT_MAX_DEFAULT     = 500000;
    localparam int DB_SYNC_STAGES_DEFAULT = 2;

    // OR-reduction of a switch vector, used for the shared change/busy flags.
    function automatic logic vec_any(input sw_vec_t v);
        return |v;
    endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch channel: synchronizer chain, STABLE/COUNTING FSM and counter.
// With SWITCH_DEBOUNCE_HOLD_EN defined a hold input freezes the channel.
module debounce_bit
    import switch_debounce_pkg::*;
#(
    parameter int CNT_MAX     = DB_CNT_MAX_DEFAULT,
    parameter int SYNC_STAGES = DB_SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
`ifdef SWITCH_DEBOUNCE_HOLD_EN
    input  logic hold,
`endif
    input  logic raw,
    output logic db,
    output logic update,
    output logic counting_next
);

    localparam int CW = $clog2(CNT_MAX);
    // Terminal count: the accepting edge happens while the counter holds this.
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   s_s;
    logic                   hold_s;
    db_state_t              state_r;
    db_state_t              state_nxt_s;
    logic [CW-1:0]          cnt_r;
    logic [CW-1:0]          cnt_nxt_s;
    logic                   db_r;
    logic                   db_nxt_s;
    logic                   upd_s;

`ifdef SWITCH_DEBOUNCE_HOLD_EN
    assign hold_s = hold;
`else
    assign hold_s = 1'b0;
`endif

    // Plain flop chain bringing the asynchronous switch into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
        end
    end

    assign s_s = sync_r[SYNC_STAGES-1];

    // Next-state, counter and output decision for this channel.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        db_nxt_s    = db_r;
        upd_s       = 1'b0;
        if (hold_s) begin
            // Frozen: drop any pending count, keep the accepted level.
            state_nxt_s = DB_STABLE;
            cnt_nxt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                DB_STABLE: begin
                    if (s_s != db_r) begin
                        state_nxt_s = DB_COUNTING;
                        cnt_nxt_s   = CNT_ONE;
                    end else begin
                        cnt_nxt_s   = CNT_ZERO;
                    end
                end
                DB_COUNTING: begin
                    if (s_s == db_r) begin
                        // Bounced back before the window closed.
                        state_nxt_s = DB_STABLE;
                        cnt_nxt_s   = CNT_ZERO;
                    end else if (cnt_r == CNT_LAST) begin
                        // Window complete: accept the new level.
                        state_nxt_s = DB_STABLE;
                        cnt_nxt_s   = CNT_ZERO;
                        db_nxt_s    = s_s;
                        upd_s       = 1'b1;
                    end else begin
                        cnt_nxt_s   = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt_s = DB_STABLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // State, counter and accepted level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= DB_STABLE;
            cnt_r   <= CNT_ZERO;
            db_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            db_r    <= db_nxt_s;
        end
    end

    assign db            = db_r;
    assign update        = upd_s;
    assign counting_next = (state_nxt_s == DB_COUNTING);

endmodule

// File: rtl/switch_debounce_4b.sv
// Four-switch debounce front end for the A/B/C/D decoder inputs.
// Each bit is debounced independently; this level merges the per-bit
// accept events into one registered change strobe and a registered busy flag.
// Defining SWITCH_DEBOUNCE_HOLD_EN adds a hold input that freezes all bits.
module switch_debounce_4b
    import switch_debounce_pkg::*;
#(
    parameter int CNT_MAX     = DB_CNT_MAX_DEFAULT,
    parameter int SYNC_STAGES = DB_SYNC_STAGES_DEFAULT
) (
    input  logic    clk,
    input  logic    rst_n,
`ifdef SWITCH_DEBOUNCE_HOLD_EN
    input  logic    hold,
`endif
    input  sw_vec_t sw_raw,
    output sw_vec_t sw_db,
    output logic    changed,
    output logic    busy
);

    sw_vec_t update_s;
    sw_vec_t counting_s;
    logic    changed_r;
    logic    busy_r;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        debounce_bit #(
            .CNT_MAX     (CNT_MAX),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_bit (
            .clk           (clk),
            .rst_n         (rst_n),
`ifdef SWITCH_DEBOUNCE_HOLD_EN
            .hold          (hold),
`endif
            .raw           (sw_raw[i]),
            .db            (sw_db[i]),
            .update        (update_s[i]),
            .counting_next (counting_s[i])
        );
    end

    // Strobe and busy are registered alongside the sw_db update so they line
    // up with the first cycle the new level is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            changed_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            changed_r <= vec_any(update_s);
            busy_r    <= vec_any(counting_s);
        end
    end

    assign changed = changed_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_switch_debounce_4b.sv
// Table-driven bench for switch_debounce_4b with CNT_MAX=8, SYNC_STAGES=2.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_switch_debounce_4b;

    localparam int CNT_MAX     = 8;
    localparam int SYNC_STAGES = 2;

    typedef struct {
        logic [3:0] raw;
        logic [3:0] db;
        logic       chg;
        logic       busy;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw_raw;
    logic [3:0] sw_db;
    logic       changed;
    logic       busy;
`ifdef SWITCH_DEBOUNCE_HOLD_EN
    logic       hold;
`endif

    int   pass_cnt;
    int   total_cnt;
    vec_t vecs[$];

    switch_debounce_4b #(
        .CNT_MAX     (CNT_MAX),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef SWITCH_DEBOUNCE_HOLD_EN
        .hold    (hold),
`endif
        .sw_raw  (sw_raw),
        .sw_db   (sw_db),
        .changed (changed),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic add_row(input logic [3:0] raw, input logic [3:0] db,
                           input logic chg, input logic bsy);
        vec_t v;
        v.raw  = raw;
        v.db   = db;
        v.chg  = chg;
        v.busy = bsy;
        vecs.push_back(v);
    endtask

    // Clean change: sampled at row 1, busy rows 3..9, accepted at row 10.
    task automatic add_clean(input logic [3:0] raw, input logic [3:0] old_db,
                             input logic [3:0] new_db);
        for (int k = 1; k <= 11; k++) begin
            add_row(raw, (k >= 10) ? new_db : old_db, (k == 10), (k >= 3 && k <= 9));
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] db,
                           input logic chg, input logic bsy);
        chk({tag, " sw_db"},   sw_db,              db);
        chk({tag, " changed"}, {3'b000, changed},  {3'b000, chg});
        chk({tag, " busy"},    {3'b000, busy},     {3'b000, bsy});
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        sw_raw    = 4'b1010;
`ifdef SWITCH_DEBOUNCE_HOLD_EN
        hold      = 1'b0;
`endif

        // Table: reset release with 1010, fall to 0000, clean A rise,
        // C bounce, then the simultaneous 0000 -> 1111 case.
        add_clean(4'b1010, 4'b0000, 4'b1010);
        add_clean(4'b0000, 4'b1010, 4'b0000);
        add_clean(4'b1000, 4'b0000, 4'b1000);
        // C bounce: 1 for rows 1-5, 0 for rows 6-7, 1 from row 8 (sampled at
        // edge 8, accepted at edge 17); first window aborts at edge 8.
        for (int k = 1; k <= 18; k++) begin
            add_row((k <= 5 || k >= 8) ? 4'b1010 : 4'b1000,
                    (k >= 17) ? 4'b1010 : 4'b1000,
                    (k == 17),
                    (k >= 3 && k <= 7) || (k >= 10 && k <= 16));
        end
        add_clean(4'b0000, 4'b1010, 4'b0000);
        add_clean(4'b1111, 4'b0000, 4'b1111);

        // Reset state.
        tick();
        tick();
        chk_out("reset", 4'b0000, 1'b0, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            sw_raw = vecs[i].raw;
            tick();
            chk_out($sformatf("row%0d", i), vecs[i].db, vecs[i].chg, vecs[i].busy);
        end

        // Reset in the middle of a pending change (count = 5 after edge 7).
        sw_raw = 4'b0101;
        for (int k = 1; k <= 7; k++) tick();
        chk_out("midcount", 4'b1111, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 4'b0000, 1'b0, 1'b0);
        tick();
        tick();
        chk_out("rst_hold", 4'b0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            chk_out($sformatf("post_rst%0d", k), (k >= 10) ? 4'b0101 : 4'b0000,
                    (k == 10), (k >= 3 && k <= 9));
        end

`ifdef SWITCH_DEBOUNCE_HOLD_EN
        // Bring D low, then toggle D under hold, then release with D=1.
        sw_raw = 4'b0100;
        for (int k = 1; k <= 11; k++) tick();
        chk_out("pre_hold", 4'b0100, 1'b0, 1'b0);
        hold = 1'b1;
        for (int k = 0; k < 20; k++) begin
            sw_raw = (k % 2 == 0) ? 4'b0101 : 4'b0100;
            tick();
            chk_out($sformatf("hold%0d", k), 4'b0100, 1'b0, 1'b0);
        end
        sw_raw = 4'b0101;
        for (int k = 1; k <= 3; k++) tick();
        hold = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk_out($sformatf("unhold%0d", k), (k >= 8) ? 4'b0101 : 4'b0100,
                    (k == 8), (k <= 7));
        end
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
